// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice (two half_add + carry OR) processes
// one bit per clock, LSB first. Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.

module half_add (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_add_ctrl #(
   parameter int width_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [width_p-1:0] a_i,
   input  logic [width_p-1:0] b_i,
`ifdef SERIAL_ADD_SUB_EN
   input  logic               sub_i,
`endif
   output logic               valid_o,
   input  logic               ready_i,
   output logic [width_p-1:0] sum_o,
   output logic               carry_o
);

   localparam int cnt_w_p = (width_p > 1) ? $clog2(width_p) : 1;
   localparam logic [cnt_w_p-1:0] last_cnt_p = cnt_w_p'(width_p - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e               state_q, state_d;
   logic [width_p-1:0]   a_q, b_q, sum_q, sum_next;
   logic [cnt_w_p-1:0]   cnt_q;
   logic                 carry_q, carry_out_q;
   logic                 accept, last_bit;
   logic                 init_carry, b_bit;
   logic                 ha0_s, ha0_c, ha1_s, ha1_c, slice_c;

`ifdef SERIAL_ADD_SUB_EN
   logic sub_q;
   // Subtraction is A + ~B + 1: invert B into the slice and seed the carry with 1.
   assign init_carry = sub_i;
   assign b_bit      = b_q[0] ^ sub_q;
`else
   assign init_carry = 1'b0;
   assign b_bit      = b_q[0];
`endif

   half_add u_ha0 (.a(a_q[0]), .b(b_bit),   .s(ha0_s), .c(ha0_c));
   half_add u_ha1 (.a(ha0_s),  .b(carry_q), .s(ha1_s), .c(ha1_c));
   assign slice_c = ha0_c | ha1_c;

   generate
      if (width_p == 1) begin : g_sum_w1
         assign sum_next = ha1_s;
      end else begin : g_sum_wn
         assign sum_next = {ha1_s, sum_q[width_p-1:1]};
      end
   endgenerate

   assign ready_o = (state_q == IDLE);
   assign valid_o = (state_q == DONE);
   assign sum_o   = sum_q;
   assign carry_o = carry_out_q;

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      last_bit = (cnt_q == last_cnt_p);
      unique case (state_q)
         IDLE: if (valid_i) begin
            accept  = 1'b1;
            state_d = RUN;
         end
         RUN:  if (last_bit) state_d = DONE;
         DONE: if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         carry_out_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         sub_q       <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= init_carry;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q   <= sub_i;
`endif
         end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            sum_q   <= sum_next;
            carry_q <= slice_c;
            // Counter saturates at the last bit; the final carry becomes the result carry.
            if (last_bit) carry_out_q <= slice_c;
            else          cnt_q       <= cnt_q + cnt_w_p'(1);
         end
      end
   end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that sequences one full-adder slice over an N-bit operand pair, one bit per clock, LSB first. The slice is two `half_add` instances plus a carry OR. The controller captures operands on a valid/ready handshake, shifts them through the slice, accumulates the sum in a shift register and holds the result until the consumer accepts it. It sits between an operand producer and a result consumer in the Adders area, trading latency for a single adder slice.

## Interface
- `width_p`, default 8: operand and sum width in bits; legal range 1 to 32.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `reset_i`  in  1: asynchronous, active-high reset.
- `valid_i`  in  1: operand pair on `a_i`/`b_i` is valid.
- `ready_o`  out  1: controller can accept operands; high only in IDLE.
- `a_i`  in  `width_p`: operand A.
- `b_i`  in  `width_p`: operand B.
- `valid_o`  out  1: result on `sum_o`/`carry_o` is valid; high only in DONE.
- `ready_i`  in  1: consumer accepts the result.
- `sum_o`  out  `width_p`: A+B modulo 2^`width_p`.
- `carry_o`  out  1: carry out of the MSB.

## Operation
- States:
  - IDLE: `ready_o`=1.
  - RUN: serial add in progress.
  - DONE: `valid_o`=1.
- IDLE→RUN on `valid_i && ready_o`:
  - Capture `a_i`/`b_i` into operand shift registers.
  - Clear the carry flop to the initial carry-in (0).
  - Clear the bit counter to 0.
- RUN, every cycle:
  - Slice inputs: operand LSBs and the carry flop.
  - Slice sum bit shifts into the MSB of the sum shift register.
  - Slice carry loads the carry flop.
  - Operand registers shift right; counter increments.
- RUN→DONE on the cycle that processes bit `width_p-1` (counter == `width_p-1`). Final carry is latched into `carry_o`.
- DONE→IDLE on `valid_o && ready_i`. Without `ready_i`, stay in DONE indefinitely with `sum_o`/`carry_o` stable.
- Changes on `a_i`/`b_i`/`valid_i` outside the IDLE handshake are ignored.
- Counter width: `$clog2(width_p)`, minimum 1 bit. It never wraps past `width_p-1`.
- `width_p`=1: RUN lasts exactly one cycle.
- Reset (asserted at any time, including mid-RUN or in DONE):
  - Immediately forces IDLE; the in-flight operation is discarded and no result is emitted.
  - `ready_o`=1, `valid_o`=0, `sum_o`=0, `carry_o`=0.
  - Operand, carry and counter registers cleared to 0.

## Timing
- Accept edge T (`valid_i && ready_o`): bits 0..`width_p-1` are processed on edges T+1..T+`width_p`.
- `valid_o` is high from edge T+`width_p`, a latency of `width_p` cycles.
- `ready_o` drops the cycle after accept and stays low through RUN and DONE.
- Result accepted at edge R: `ready_o`=1 from R. The earliest next accept is edge R+1.
- Throughput: one result per `width_p`+1 cycles with `ready_i` tied high.
- `ready_o` and `valid_o` are decoded from registered state only. There are no combinational paths from `valid_i` or `ready_i` to any output.

## Configuration
- `SERIAL_ADD_SUB_EN` defined:
  - Adds port `sub_i` (in, 1), sampled with the operands at accept.
  - When `sub_i`=1, B bits are inverted into the slice and the initial carry is 1. `sum_o` = A−B mod 2^`width_p`; `carry_o`=1 means no borrow (A≥B unsigned).
  - When `sub_i`=0, behaviour is identical to addition.
- Macro undefined: no `sub_i` port; addition only; initial carry fixed at 0.

## Test plan
- `width_p`=8, accept A=0x3C, B=0x45, `ready_i`=1 → `valid_o` high exactly 8 cycles after accept; `sum_o`=0x81, `carry_o`=0; `ready_o` high the following cycle.
- A=0xFF, B=0x01 → `sum_o`=0x00, `carry_o`=1. Then A=0x00, B=0x00 back-to-back → `sum_o`=0x00, `carry_o`=0 (no stale carry).
- A=0xAA, B=0x55, `ready_i` held low 5 cycles after `valid_o` → `sum_o`=0xFF, `carry_o`=0 stable throughout; `valid_i` pulses during the wait are ignored; transfer completes on the first `ready_i`=1 cycle.
- Assert `reset_i` for 1 cycle at bit 4 of a RUN → immediately `ready_o`=1, `valid_o`=0, `sum_o`=0. Next accept A=0x01, B=0x02 → 0x03, `carry_o`=0.
- `SERIAL_ADD_SUB_EN`, `sub_i`=1: A=0x10, B=0x01 → `sum_o`=0x0F, `carry_o`=1. A=0x01, B=0x02 → `sum_o`=0xFF, `carry_o`=0.
- `width_p`=1: A=1, B=1 → `valid_o` one cycle after accept, `sum_o`=0, `carry_o`=1.
